prog_sequencer: RTL and testbench

Parametrised program sequencer for the 9-bit RISC core, replacing the free-running program counter, jump lookup and hard-wired halt-address done flag. It holds the PC, resolves taken branches through a jump-target table, and runs one of NUM_PROGS programs per start request, each with its own start and halt address. It adds stall support, a cycle counter, a timeout and a start/done handshake. It sits between Ctrl/ALU (branch request) and InstROM (PC).

---
 rtl/seq_pkg.sv | 24 ++
 rtl/jump_lut.sv | 17 +
 rtl/prog_sequencer.sv | 134 +++++++++++++
 tb/tb_prog_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and types for the program sequencer.
// Default program map and jump table for the 9-bit RISC core.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Entry 0 sits in the least significant word.
  localparam logic [2:0][31:0] START_ADDR = {
    32'd128, 32'd64, 32'd0
  };

  localparam logic [2:0][31:0] HALT_ADDR = {
    32'd200, 32'd100, 32'd58
  };

  // Entry 3 jumps to 20; every other entry is 0.
  localparam logic [31:0][31:0] JUMP_LUT =
    1024'd20 << 96;

endpackage

// File: rtl/jump_lut.sv
// Branch target table: jump pointer to PC.
// Purely combinational.
module jump_lut
  import seq_pkg::*;
#(
  parameter int JPTR_W = 5,
  parameter int PC_W   = 12,
  parameter logic [2**JPTR_W-1:0][31:0] LUT =
    JUMP_LUT
) (
  input  logic [JPTR_W-1:0] Jptr,
  output logic [PC_W-1:0]   target
);

  assign target = PC_W'(LUT[Jptr]);

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, branch resolution, per-program
// start/halt, stall, cycle count, timeout and handshake.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W       = 12,
  parameter int JPTR_W     = 5,
  parameter int NUM_PROGS  = 3,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096,
  parameter int SEL_W      =
    (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  parameter logic [NUM_PROGS-1:0][31:0] START_TBL =
    START_ADDR,
  parameter logic [NUM_PROGS-1:0][31:0] HALT_TBL =
    HALT_ADDR,
  parameter logic [2**JPTR_W-1:0][31:0] JUMP_TBL =
    JUMP_LUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  prog_sel,
  input  logic              Jen,
  input  logic              Brc_J,
  input  logic [JPTR_W-1:0] Jptr,
  input  logic              stall,
  output logic [PC_W-1:0]   PC,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              bad_sel,
  output logic [CNT_W-1:0]  cycles
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [SEL_W-1:0] prog_q, prog_d;
  logic             to_q, to_d;
  logic             bad_q, bad_d;
  logic [PC_W-1:0]  target;
  logic             sel_ok;
  logic             at_halt;
  logic             at_limit;

  jump_lut #(
    .JPTR_W (JPTR_W),
    .PC_W   (PC_W),
    .LUT    (JUMP_TBL)
  ) u_lut (
    .Jptr   (Jptr),
    .target (target)
  );

  assign sel_ok   = int'(prog_sel) < NUM_PROGS;
  assign at_halt  =
    pc_q == PC_W'(HALT_TBL[prog_q]);
  assign at_limit =
    cyc_q == CNT_W'(MAX_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    prog_d  = prog_q;
    to_d    = to_q;
    bad_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && sel_ok) begin
          pc_d    = PC_W'(START_TBL[prog_sel]);
          prog_d  = prog_sel;
          cyc_d   = '0;
          to_d    = 1'b0;
          state_d = RUN;
        end else if (start) begin
          bad_d = 1'b1;
        end
      end
      RUN: begin
        // Exits freeze the counter at its last RUN value.
        if (at_halt) begin
          to_d    = 1'b0;
          state_d = DONE;
        end else if (at_limit) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cyc_d = cyc_q + 1'b1;
          if (stall) begin
            pc_d = pc_q;
          end else if (Jen && Brc_J) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
      prog_q  <= '0;
      to_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      prog_q  <= prog_d;
      to_q    <= to_d;
      bad_q   <= bad_d;
    end
  end

  assign PC      = pc_q;
  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign timeout = to_q;
  assign bad_sel = bad_q;
  assign cycles  = cyc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: default, short-timeout
// and 6-bit-PC instances driven from shared stimulus.
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] prog_sel;
  logic       jen;
  logic       brc;
  logic [4:0] jptr;
  logic       stall;

  logic [11:0] pc_a;
  logic        busy_a, done_a, to_a, bad_a;
  logic [15:0] cyc_a;
  logic [11:0] pc_b;
  logic        busy_b, done_b, to_b, bad_b;
  logic [15:0] cyc_b;
  logic [5:0]  pc_c;
  logic        busy_c, done_c, to_c, bad_c;
  logic [15:0] cyc_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_sequencer u_a (
    .clk(clk), .reset(rst_n), .start(start),
    .prog_sel(prog_sel), .Jen(jen), .Brc_J(brc),
    .Jptr(jptr), .stall(stall), .PC(pc_a),
    .busy(busy_a), .done(done_a), .timeout(to_a),
    .bad_sel(bad_a), .cycles(cyc_a)
  );

  prog_sequencer #(.MAX_CYCLES(16)) u_b (
    .clk(clk), .reset(rst_n), .start(start),
    .prog_sel(prog_sel), .Jen(jen), .Brc_J(brc),
    .Jptr(jptr), .stall(stall), .PC(pc_b),
    .busy(busy_b), .done(done_b), .timeout(to_b),
    .bad_sel(bad_b), .cycles(cyc_b)
  );

  prog_sequencer #(
    .PC_W(6),
    .START_TBL({32'd0, 32'd0, 32'd62}),
    .HALT_TBL({32'd50, 32'd50, 32'd40})
  ) u_c (
    .clk(clk), .reset(rst_n), .start(start),
    .prog_sel(prog_sel), .Jen(jen), .Brc_J(brc),
    .Jptr(jptr), .stall(stall), .PC(pc_c),
    .busy(busy_c), .done(done_c), .timeout(to_c),
    .bad_sel(bad_c), .cycles(cyc_c)
  );

  task automatic check(input string tag,
                       input int unsigned got,
                       input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_sel = 2'd0;
    jen = 1'b0; brc = 1'b0; jptr = 5'd0;
    stall = 1'b0;
    tick(); tick();
    check("rst_pc", pc_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_to", to_a, 0);
    check("rst_bad", bad_a, 0);
    check("rst_cyc", cyc_a, 0);
    rst_n = 1'b1;
    tick();

    // prog 0 runs 0..58; u_b times out; u_c wraps
    start = 1'b1; prog_sel = 2'd0;
    tick();
    start = 1'b0;
    check("p0_pc0", pc_a, 0);
    check("p0_busy", busy_a, 1);
    check("p0_cyc0", cyc_a, 0);
    check("w6_pc62", pc_c, 62);
    for (int i = 1; i <= 58; i++) begin
      tick();
      if (done_a) check("p0_early_done", done_a, 0);
      if (i == 1) check("w6_pc63", pc_c, 63);
      if (i == 2) check("w6_wrap", pc_c, 0);
      if (i == 15) begin
        check("to_pc15", pc_b, 15);
        check("to_busy", busy_b, 1);
      end
      if (i == 16) begin
        check("to_done", done_b, 1);
        check("to_flag", to_b, 1);
        check("to_cyc", cyc_b, 15);
        check("to_busy0", busy_b, 0);
      end
      if (i == 17) check("to_done1", done_b, 0);
    end
    check("p0_pc58", pc_a, 58);
    check("p0_cyc58", cyc_a, 58);
    check("p0_busy58", busy_a, 1);
    tick();
    check("p0_done", done_a, 1);
    check("p0_dbusy", busy_a, 0);
    check("p0_dcyc", cyc_a, 58);
    check("p0_dto", to_a, 0);
    check("p0_dpc", pc_a, 58);

    // start during done is ignored, next cycle accepted
    start = 1'b1; prog_sel = 2'd1;
    tick();
    check("dn_ign_done", done_a, 0);
    check("dn_ign_busy", busy_a, 0);
    check("dn_ign_pc", pc_a, 58);
    tick();
    check("p1_busy", busy_a, 1);
    check("p1_pc64", pc_a, 64);

    // start in RUN ignored, then branches
    prog_sel = 2'd0;
    tick();
    start = 1'b0;
    check("run_ign_pc", pc_a, 65);
    check("run_ign_busy", busy_a, 1);
    tick();
    check("p1_pc66", pc_a, 66);
    jen = 1'b1; brc = 1'b1; jptr = 5'd3;
    tick();
    check("br_taken", pc_a, 20);
    brc = 1'b0;
    tick();
    check("br_not", pc_a, 21);
    check("br_cyc", cyc_a, 4);
    jen = 1'b0; jptr = 5'd0;
    repeat (9) tick();
    check("pre_rst_pc", pc_a, 30);
    rst_n = 1'b0;
    tick();
    check("mr_pc", pc_a, 0);
    check("mr_busy", busy_a, 0);
    check("mr_done", done_a, 0);
    rst_n = 1'b1;
    tick();
    check("mr_done2", done_a, 0);
    check("mr_busy2", busy_a, 0);

    // invalid program select
    start = 1'b1; prog_sel = 2'd3;
    tick();
    start = 1'b0;
    check("bad_pulse", bad_a, 1);
    check("bad_busy", busy_a, 0);
    check("bad_pc", pc_a, 0);
    tick();
    check("bad_clr", bad_a, 0);
    check("bad_idle", busy_a, 0);

    // stall in prog 1
    start = 1'b1; prog_sel = 2'd1;
    tick();
    start = 1'b0;
    check("st_pc64", pc_a, 64);
    repeat (6) tick();
    check("st_pc70", pc_a, 70);
    check("st_cyc6", cyc_a, 6);
    stall = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      tick();
      check("st_hold", pc_a, 70);
      check("st_cyc", cyc_a, 6 + s);
    end
    stall = 1'b0;
    tick();
    check("st_pc71", pc_a, 71);
    check("st_cyc10", cyc_a, 10);
    repeat (29) tick();
    check("st_pc100", pc_a, 100);
    check("st_cyc39", cyc_a, 39);
    check("st_busy", busy_a, 1);
    tick();
    check("st_done", done_a, 1);
    check("st_dcyc", cyc_a, 39);
    check("st_dto", to_a, 0);
    check("st_dpc", pc_a, 100);
    tick();
    check("st_done1", done_a, 0);
    check("st_idle", busy_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
